pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised pipeline-stage register for the RISC-V pipelined core, replacing the fixed-field, enable-only inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an arbitrary-width payload with a valid/ready handshake. A two-entry skid buffer gives full throughput under back-pressure, and a synchronous flush inserts bubbles on branch mispredict. Built-in counters report stall cycles and completed transfers for performance monitoring.

## Interface
Parameters:
- PAYLOAD_W, 165, payload width in bits; default is the ID/EX bundle: rs1, rs2, pc, immExt, pcPlus4 at 32 bits each, plus rdAddr at 5 bits.
- CNT_W, 32, width of both performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_data  in  PAYLOAD_W  upstream payload.
- flush  in  1  synchronous squash of all held entries.
- out_valid  out  1  main entry holds a payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  PAYLOAD_W  main entry payload; all zeros when out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturates at all-ones.
- xfer_cnt  out  CNT_W  completed output transfers; wraps modulo 2^CNT_W.

## Operation
- Accept condition: in_valid AND in_ready. Take condition: out_valid AND out_ready.
- Storage:
  - main register: main_data and main_valid.
  - skid register: skid_data and skid_valid.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY = 00
  - FULL = 01
  - SKID = 11
  - 10 is illegal; flag it with an assertion.
- EMPTY:
  - accept -> FULL, main_data <= in_data.
  - otherwise stay.
- FULL:
  - accept and take -> FULL, main_data <= in_data.
  - accept only -> SKID, skid_data <= in_data.
  - take only -> EMPTY.
  - neither -> stay.
- SKID:
  - in_ready=0, so no accept is possible.
  - take -> FULL, main_data <= skid_data, skid_data <= 0.
  - otherwise stay.
- Flush:
  - Next state is EMPTY, with both data registers zeroed.
  - Flush overrides every other transition.
  - A payload accepted in the flush cycle is discarded. The upstream handshake still counts as completed.
  - A take in the flush cycle completes normally and is counted in xfer_cnt.
- Bubble rule: whenever a valid bit is cleared, the matching data register is cleared to zero. Downstream therefore never sees stale rdAddr or pc.
- Counters:
  - stall_cnt increments while out_valid AND NOT out_ready; it holds at all-ones.
  - xfer_cnt increments on each take.
  - Flush does not clear either counter; only reset does.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - out_data=0
  - stall_cnt=0
  - xfer_cnt=0
  - internal: skid_valid=0, skid_data=0.
- Reset may assert mid-transfer; every register clears immediately, without waiting for clk.
- Latency: a payload accepted at edge N appears on out_data and out_valid after edge N, with 1 cycle latency.
- Throughput: 1 payload per cycle while out_ready=1.
- in_ready and out_data are driven only from registers, with no combinational path from in_* to out_*. out_ready→in_ready is also registered.
- First cycle of back-pressure: one extra payload lands in skid, and in_ready drops after that edge.
- Skid drains into main on the next take. in_ready returns high after that edge.

## Structure
- Package pipe_pkg holds:
  - the stage state encoding.
  - payload field widths and bit offsets for each inter-stage bundle: ID/EX rs1, rs2, pc, rdAddr, immExt, pcPlus4, and equivalents for the other stages.
  - a PAYLOAD_W constant per stage.
- Sub-module sat_counter(W, SATURATE) implements the counters: stall_cnt uses SATURATE=1, xfer_cnt uses SATURATE=0.

## Test plan
- Reset with in_valid=1 -> out_valid=0, out_data=0, in_ready=1. Deassert reset, drive in_data=0x1 -> out_data=0x1 and out_valid=1 one cycle later.
- Stream 0x10, 0x11, 0x12 with out_ready=1 throughout -> outputs in order on consecutive cycles, xfer_cnt=3, stall_cnt=0.
- Send 0xA, then 0xB, then drop out_ready for 3 cycles -> 0xB captured in skid, in_ready=0, stall_cnt=3. Release -> 0xA then 0xB delivered, nothing lost or duplicated.
- Flush while in SKID with in_valid=1 (0xC) -> next cycle out_valid=0, out_data=0, in_ready=1; 0xC never appears.
- Force out_ready=0 with CNT_W=4 for 20 cycles -> stall_cnt holds at 15. Then 17 transfers -> xfer_cnt wraps to 1.
- Assert reset asynchronously between edges while in SKID -> all outputs zero before the next clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: stage state
// encoding and the field layout of each inter-stage payload bundle.
package pipe_pkg;

    // Stage occupancy, encoded as {skid_valid, main_valid}; 2'b10 is unused.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b11
    } stage_state_t;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // ---------------------------------------------------------------
    // IF/ID bundle: {pc, instr, pcPlus4}
    // ---------------------------------------------------------------
    localparam int unsigned IFID_PCPLUS4_LSB = 0;
    localparam int unsigned IFID_PCPLUS4_W   = XLEN;
    localparam int unsigned IFID_INSTR_LSB   = IFID_PCPLUS4_LSB + IFID_PCPLUS4_W;
    localparam int unsigned IFID_INSTR_W     = XLEN;
    localparam int unsigned IFID_PC_LSB      = IFID_INSTR_LSB + IFID_INSTR_W;
    localparam int unsigned IFID_PC_W        = XLEN;
    localparam int unsigned IFID_W           = IFID_PC_LSB + IFID_PC_W;

    // ---------------------------------------------------------------
    // ID/EX bundle: {rs1, rs2, pc, rdAddr, immExt, pcPlus4}
    // ---------------------------------------------------------------
    localparam int unsigned IDEX_PCPLUS4_LSB = 0;
    localparam int unsigned IDEX_PCPLUS4_W   = XLEN;
    localparam int unsigned IDEX_IMMEXT_LSB  = IDEX_PCPLUS4_LSB + IDEX_PCPLUS4_W;
    localparam int unsigned IDEX_IMMEXT_W    = XLEN;
    localparam int unsigned IDEX_RDADDR_LSB  = IDEX_IMMEXT_LSB + IDEX_IMMEXT_W;
    localparam int unsigned IDEX_RDADDR_W    = REG_ADDR_W;
    localparam int unsigned IDEX_PC_LSB      = IDEX_RDADDR_LSB + IDEX_RDADDR_W;
    localparam int unsigned IDEX_PC_W        = XLEN;
    localparam int unsigned IDEX_RS2_LSB     = IDEX_PC_LSB + IDEX_PC_W;
    localparam int unsigned IDEX_RS2_W       = XLEN;
    localparam int unsigned IDEX_RS1_LSB     = IDEX_RS2_LSB + IDEX_RS2_W;
    localparam int unsigned IDEX_RS1_W       = XLEN;
    localparam int unsigned IDEX_W           = IDEX_RS1_LSB + IDEX_RS1_W;

    // ---------------------------------------------------------------
    // EX/MEM bundle: {aluResult, writeData, pcPlus4, rdAddr}
    // ---------------------------------------------------------------
    localparam int unsigned EXMEM_RDADDR_LSB  = 0;
    localparam int unsigned EXMEM_RDADDR_W    = REG_ADDR_W;
    localparam int unsigned EXMEM_PCPLUS4_LSB = EXMEM_RDADDR_LSB + EXMEM_RDADDR_W;
    localparam int unsigned EXMEM_PCPLUS4_W   = XLEN;
    localparam int unsigned EXMEM_WDATA_LSB   = EXMEM_PCPLUS4_LSB + EXMEM_PCPLUS4_W;
    localparam int unsigned EXMEM_WDATA_W     = XLEN;
    localparam int unsigned EXMEM_ALU_LSB     = EXMEM_WDATA_LSB + EXMEM_WDATA_W;
    localparam int unsigned EXMEM_ALU_W       = XLEN;
    localparam int unsigned EXMEM_W           = EXMEM_ALU_LSB + EXMEM_ALU_W;

    // ---------------------------------------------------------------
    // MEM/WB bundle: {aluResult, readData, pcPlus4, rdAddr}
    // ---------------------------------------------------------------
    localparam int unsigned MEMWB_RDADDR_LSB  = 0;
    localparam int unsigned MEMWB_RDADDR_W    = REG_ADDR_W;
    localparam int unsigned MEMWB_PCPLUS4_LSB = MEMWB_RDADDR_LSB + MEMWB_RDADDR_W;
    localparam int unsigned MEMWB_PCPLUS4_W   = XLEN;
    localparam int unsigned MEMWB_RDATA_LSB   = MEMWB_PCPLUS4_LSB + MEMWB_PCPLUS4_W;
    localparam int unsigned MEMWB_RDATA_W     = XLEN;
    localparam int unsigned MEMWB_ALU_LSB     = MEMWB_RDATA_LSB + MEMWB_RDATA_W;
    localparam int unsigned MEMWB_ALU_W       = XLEN;
    localparam int unsigned MEMWB_W           = MEMWB_ALU_LSB + MEMWB_ALU_W;

    // Assemble an ID/EX payload in the bit order defined above.
    function automatic logic [IDEX_W-1:0] idex_pack(
        input logic [XLEN-1:0]       rs1,
        input logic [XLEN-1:0]       rs2,
        input logic [XLEN-1:0]       pc,
        input logic [REG_ADDR_W-1:0] rd_addr,
        input logic [XLEN-1:0]       imm_ext,
        input logic [XLEN-1:0]       pc_plus4
    );
        return {rs1, rs2, pc, rd_addr, imm_ext, pc_plus4};
    endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Event counter with optional saturation at all-ones; cleared only by reset.
module sat_counter #(
    parameter int unsigned W        = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count qualifying cycles; hold at all-ones when saturating, else wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            if (!(SATURATE && (count == '1))) begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Generic valid/ready pipeline-stage register with a two-entry skid buffer,
// synchronous flush, and stall/transfer performance counters.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 165,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     xfer_cnt
);

    stage_state_t         state;
    logic [PAYLOAD_W-1:0] main_data;
    logic [PAYLOAD_W-1:0] skid_data;
    logic                 main_valid;
    logic                 skid_valid;
    logic                 accept;
    logic                 take;

    // The state register doubles as the two valid bits, so in_ready and
    // out_valid come straight from flops.
    assign main_valid = state[0];
    assign skid_valid = state[1];
    assign in_ready   = ~skid_valid;
    assign out_valid  = main_valid;
    assign out_data   = main_data;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    // Stage FSM: moves payloads between input, skid and main registers;
    // any register whose valid bit drops is zeroed in the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state     <= ST_FULL;
                        main_data <= in_data;
                    end
                end
                ST_FULL: begin
                    if (accept && take) begin
                        main_data <= in_data;
                    end else if (accept) begin
                        state     <= ST_SKID;
                        skid_data <= in_data;
                    end else if (take) begin
                        state     <= ST_EMPTY;
                        main_data <= '0;
                    end
                end
                ST_SKID: begin
                    if (take) begin
                        state     <= ST_FULL;
                        main_data <= skid_data;
                        skid_data <= '0;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    main_data <= '0;
                    skid_data <= '0;
                end
            endcase
        end
    end

    // The skid entry must never be occupied while main is empty
    assert property (@(posedge clk) disable iff (reset)
        !(skid_valid && !main_valid));

    sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b1)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(
        .W        (CNT_W),
        .SATURATE (1'b0)
    ) u_xfer_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (take),
        .count (xfer_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a queue-based model.
module tb_pipe_skid_stage;

    localparam int PW = 165;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] xfer_cnt;

    pipe_skid_stage #(
        .PAYLOAD_W (PW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of capacity two
    logic [PW-1:0] mq[$];
    int            m_stall;
    int            m_xfer;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_stall = 0;
        m_xfer  = 0;
    endtask

    task automatic model_edge(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        bit acc;
        bit tk;
        acc = v && (mq.size() < 2);
        tk  = (mq.size() > 0) && r;
        if ((mq.size() > 0) && !r && (m_stall != CNT_MAX)) m_stall++;
        if (tk) m_xfer = (m_xfer + 1) % (CNT_MAX + 1);
        if (f) begin
            mq.delete();
        end else begin
            if (tk) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        logic [PW-1:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", 192'(out_valid), 192'(mq.size() > 0));
        chk("in_ready",  192'(in_ready),  192'(mq.size() < 2));
        chk("out_data",  192'(out_data),  192'(exp_data));
        chk("stall_cnt", 192'(stall_cnt), 192'(m_stall));
        chk("xfer_cnt",  192'(xfer_cnt),  192'(m_xfer));
    endtask

    task automatic cycle(input logic v, input logic [PW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        model_edge(v, d, r, f);
        #1;
        check_all();
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [191:0] w;
        w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return w[PW-1:0];
    endfunction

    initial begin
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;

        // Reset held with a payload offered upstream
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = PW'(5);
        out_ready = 1'b1;
        flush     = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // First payload appears one cycle after acceptance
        cycle(1'b1, PW'(1), 1'b1, 1'b0);
        chk("first_data", 192'(out_data), 192'(1));

        // Back-to-back stream at full throughput
        cycle(1'b1, PW'('h10), 1'b1, 1'b0);
        cycle(1'b1, PW'('h11), 1'b1, 1'b0);
        cycle(1'b1, PW'('h12), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Back-pressure: second payload lands in skid, then drains in order
        cycle(1'b1, PW'('hA), 1'b1, 1'b0);
        cycle(1'b1, PW'('hB), 1'b0, 1'b0);
        chk("skid_in_ready", 192'(in_ready), 192'(0));
        cycle(1'b1, PW'('hD), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_b", 192'(out_data), 192'('hB));
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush while in SKID with a new payload offered
        cycle(1'b1, PW'('h1A), 1'b0, 1'b0);
        cycle(1'b1, PW'('h1B), 1'b0, 1'b0);
        cycle(1'b1, PW'('hC), 1'b0, 1'b1);
        chk("flush_valid", 192'(out_valid), 192'(0));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Stall counter saturation, then transfer counter wrap
        cycle(1'b1, PW'('h20), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("stall_sat", 192'(stall_cnt), 192'(CNT_MAX));
        for (int i = 0; i < 17; i++) cycle(1'b1, rand_payload(), 1'b1, 1'b0);

        // Asynchronous reset between edges while in SKID
        pa = rand_payload();
        pb = rand_payload();
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, pa, 1'b0, 1'b0);
        cycle(1'b1, pb, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        reset = 1'b0;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_payload(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
